// File: rtl/addr_xlate_tlb.sv
// MIPS virtual-to-physical translator: fixed kseg0/kseg1 mapping plus a
// fully-associative TLB for mapped segments, with a TLBP probe port.
module addr_xlate_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int PA_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [31:0]      in_vaddr,
  input  logic             in_store,
  input  logic             stall,
  input  logic             user_mode,
  input  logic [7:0]       cur_asid,
  input  logic             k0_uncached,
  output logic             out_valid,
  output logic [PA_W-1:0]  out_paddr,
  output logic             out_uncache,
  output logic             out_mapped,
  output logic             out_exc_addr,
  output logic             out_exc_refill,
  output logic             out_exc_invalid,
  output logic             out_exc_modified,
  input  logic             tlbw_en,
  input  logic [IDX_W-1:0] tlbw_index,
  input  logic [18:0]      tlbw_vpn2,
  input  logic [7:0]       tlbw_asid,
  input  logic             tlbw_g,
  input  logic [19:0]      tlbw_pfn0,
  input  logic [19:0]      tlbw_pfn1,
  input  logic [2:0]       tlbw_c0,
  input  logic [2:0]       tlbw_c1,
  input  logic             tlbw_d0,
  input  logic             tlbw_d1,
  input  logic             tlbw_v0,
  input  logic             tlbw_v1,
  input  logic             tlbp_en,
  input  logic [18:0]      tlbp_vpn2,
  input  logic [7:0]       tlbp_asid,
  output logic             tlbp_done,
  output logic             tlbp_hit,
  output logic [IDX_W-1:0] tlbp_index
);

  logic [18:0] e_vpn2 [TLB_ENTRIES];
  logic [7:0]  e_asid [TLB_ENTRIES];
  logic        e_g    [TLB_ENTRIES];
  logic [19:0] e_pfn0 [TLB_ENTRIES];
  logic [19:0] e_pfn1 [TLB_ENTRIES];
  logic [2:0]  e_c0   [TLB_ENTRIES];
  logic [2:0]  e_c1   [TLB_ENTRIES];
  logic        e_d0   [TLB_ENTRIES];
  logic        e_d1   [TLB_ENTRIES];
  logic        e_v0   [TLB_ENTRIES];
  logic        e_v1   [TLB_ENTRIES];

  // All fields are cleared (not just V/G/D) so a stale entry can never
  // match an arbitrary address with a nonzero ASID after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_pfn0[i] <= '0;
        e_pfn1[i] <= '0;
        e_c0[i]   <= '0;
        e_c1[i]   <= '0;
        e_d0[i]   <= 1'b0;
        e_d1[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end
    end else if (tlbw_en) begin
      e_vpn2[tlbw_index] <= tlbw_vpn2;
      e_asid[tlbw_index] <= tlbw_asid;
      e_g[tlbw_index]    <= tlbw_g;
      e_pfn0[tlbw_index] <= tlbw_pfn0;
      e_pfn1[tlbw_index] <= tlbw_pfn1;
      e_c0[tlbw_index]   <= tlbw_c0;
      e_c1[tlbw_index]   <= tlbw_c1;
      e_d0[tlbw_index]   <= tlbw_d0;
      e_d1[tlbw_index]   <= tlbw_d1;
      e_v0[tlbw_index]   <= tlbw_v0;
      e_v1[tlbw_index]   <= tlbw_v1;
    end
  end

  logic [TLB_ENTRIES-1:0] lk_match;
  logic [TLB_ENTRIES-1:0] pr_match;

  always_comb begin
    lk_match = '0;
    pr_match = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      lk_match[i] = (e_vpn2[i] == in_vaddr[31:13]) &&
                    (e_g[i] || (e_asid[i] == cur_asid));
      pr_match[i] = (e_vpn2[i] == tlbp_vpn2) &&
                    (e_g[i] || (e_asid[i] == tlbp_asid));
    end
  end

  // Downward scan leaves the lowest matching index, so duplicate entries
  // resolve deterministically.
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             pr_hit;
  logic [IDX_W-1:0] pr_idx;

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (pr_match[i]) begin
        pr_hit = 1'b1;
        pr_idx = IDX_W'(i);
      end
    end
  end

  logic        sel_v;
  logic        sel_d;
  logic [19:0] sel_pfn;
  logic [2:0]  sel_c;

  always_comb begin
    if (in_vaddr[12]) begin
      sel_v   = e_v1[lk_idx];
      sel_d   = e_d1[lk_idx];
      sel_pfn = e_pfn1[lk_idx];
      sel_c   = e_c1[lk_idx];
    end else begin
      sel_v   = e_v0[lk_idx];
      sel_d   = e_d0[lk_idx];
      sel_pfn = e_pfn0[lk_idx];
      sel_c   = e_c0[lk_idx];
    end
  end

  logic [31:0] res_pa;
  logic        res_uncache;
  logic        res_mapped;
  logic        res_exc_addr;
  logic        res_exc_refill;
  logic        res_exc_invalid;
  logic        res_exc_modified;

  // Any exception forces paddr/uncache to zero; flags are prioritised so
  // only one can be set.
  always_comb begin
    res_pa           = '0;
    res_uncache      = 1'b0;
    res_mapped       = 1'b0;
    res_exc_addr     = 1'b0;
    res_exc_refill   = 1'b0;
    res_exc_invalid  = 1'b0;
    res_exc_modified = 1'b0;
    if (user_mode && in_vaddr[31]) begin
      res_exc_addr = 1'b1;
    end else if (in_vaddr[31:29] == 3'b100) begin
      res_pa      = {3'b000, in_vaddr[28:0]};
      res_uncache = k0_uncached;
    end else if (in_vaddr[31:29] == 3'b101) begin
      res_pa      = {3'b000, in_vaddr[28:0]};
      res_uncache = 1'b1;
    end else begin
      res_mapped = 1'b1;
      if (!lk_hit) begin
        res_exc_refill = 1'b1;
      end else if (!sel_v) begin
        res_exc_invalid = 1'b1;
      end else if (in_store && !sel_d) begin
        res_exc_modified = 1'b1;
      end else begin
        res_pa      = {sel_pfn, in_vaddr[11:0]};
        res_uncache = (sel_c == 3'd2);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid        <= 1'b0;
      out_paddr        <= '0;
      out_uncache      <= 1'b0;
      out_mapped       <= 1'b0;
      out_exc_addr     <= 1'b0;
      out_exc_refill   <= 1'b0;
      out_exc_invalid  <= 1'b0;
      out_exc_modified <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        out_valid        <= 1'b1;
        out_paddr        <= PA_W'(res_pa);
        out_uncache      <= res_uncache;
        out_mapped       <= res_mapped;
        out_exc_addr     <= res_exc_addr;
        out_exc_refill   <= res_exc_refill;
        out_exc_invalid  <= res_exc_invalid;
        out_exc_modified <= res_exc_modified;
      end else begin
        out_valid        <= 1'b0;
        out_paddr        <= '0;
        out_uncache      <= 1'b0;
        out_mapped       <= 1'b0;
        out_exc_addr     <= 1'b0;
        out_exc_refill   <= 1'b0;
        out_exc_invalid  <= 1'b0;
        out_exc_modified <= 1'b0;
      end
    end
  end

  // Probe path ignores stall so a CP0 TLBP always completes in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tlbp_done  <= 1'b0;
      tlbp_hit   <= 1'b0;
      tlbp_index <= '0;
    end else begin
      tlbp_done  <= tlbp_en;
      tlbp_hit   <= tlbp_en && pr_hit;
      tlbp_index <= (tlbp_en && pr_hit) ? pr_idx : '0;
    end
  end

endmodule

// File: doc/addr_xlate_tlb.md
Name: addr_xlate_tlb

Overview:
Next-generation virtual-to-physical address translator for the MIPS core. It keeps the fixed kseg0/kseg1 direct mapping and adds a parametrised fully-associative TLB for useg/kseg2/kseg3, plus TLB exception detection and a TLBP probe port. Lookup is registered, with one-cycle latency, and sits between the fetch/memory-stage address generation and the cache request logic. The TLB is written by the CP0 TLBWI/TLBWR path.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of 2, 2..64)
IDX_W, $clog2(TLB_ENTRIES), TLB index width
PA_W, 32, physical address width; upper bits of the PFN are truncated

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, active-low, asynchronous assert
in_valid  in  1  lookup request valid
in_vaddr  in  32  virtual address
in_store  in  1  request is a store (for the dirty check)
stall  in  1  hold the output register
user_mode  in  1  CP0 Status: user mode
cur_asid  in  8  CP0 EntryHi.ASID
k0_uncached  in  1  Config.K0==2
out_valid  out  1  result valid
out_paddr  out  PA_W  physical address
out_uncache  out  1  access is uncached
out_mapped  out  1  translated via TLB
out_exc_addr  out  1  address error (kernel segment accessed in user mode)
out_exc_refill  out  1  TLB miss
out_exc_invalid  out  1  hit, V=0
out_exc_modified  out  1  store hit, V=1, D=0
tlbw_en  in  1  write entry
tlbw_index  in  IDX_W  entry to write
tlbw_vpn2  in  19  EntryHi.VPN2
tlbw_asid  in  8  EntryHi.ASID
tlbw_g  in  1  global (G0&G1)
tlbw_pfn0/tlbw_pfn1  in  20 each  PFN for even/odd page
tlbw_c0/tlbw_c1  in  3 each  cache attribute
tlbw_d0/tlbw_d1, tlbw_v0/tlbw_v1  in  1 each  dirty/valid bits
tlbp_en  in  1  probe request
tlbp_vpn2  in  19  probe VPN2
tlbp_asid  in  8  probe ASID
tlbp_done  out  1  probe result valid (1-cycle pulse)
tlbp_hit  out  1  probe matched
tlbp_index  out  IDX_W  matching index

Behaviour:
- Reset (async on resetn low, effective immediately, including mid-operation):
  - All outputs are 0.
  - All entry V0/V1/G/D bits are cleared; other entry fields are don't-care.
- Lookup timing:
  - The request is captured on the rising edge when in_valid=1 and stall=0; the result appears next cycle (latency 1).
  - stall=1 freezes all out_* registers.
  - in_valid=0 with stall=0 clears out_valid and all exc flags.
- Segment decode on in_vaddr[31:29]:
  - 100 (kseg0): paddr={3'b000,va[28:0]}, uncache=k0_uncached, mapped=0.
  - 101 (kseg1): paddr={3'b000,va[28:0]}, uncache=1, mapped=0.
  - 0xx, 110, 111: mapped=1, translated via the TLB.
- Privilege check: user_mode=1 and va[31]=1 sets exc_addr only. No TLB exception is raised and paddr=0.
- TLB match:
  - Entry i matches when vpn2_i==va[31:13] and (g_i or asid_i==cur_asid).
  - va[12] selects the odd (1) or even (0) half.
  - No match: exc_refill=1. Match with V=0: exc_invalid=1. Match, V=1, D=0, in_store=1: exc_modified=1.
  - Otherwise: paddr={pfn,va[11:0]} truncated to PA_W, uncache=(C==3'd2).
  - On any exception, paddr=0 and uncache=0. Exception flags are mutually exclusive.
- Multiple matches (software error): the lowest index wins. The result is deterministic and there is no X propagation.
- Write:
  - tlbw_en writes all fields of entry tlbw_index on the clock edge.
  - A lookup or probe in the same cycle sees the pre-write contents; the new contents are visible from the next cycle.
- Probe:
  - tlbp_en samples the probe inputs (same match rule, G honoured). Next cycle: tlbp_done=1, tlbp_hit, and tlbp_index (0 on miss).
  - tlbp_done is a single-cycle pulse and is independent of stall.
  - Probe and lookup may occur in the same cycle; they are independent.

Test Plan:
- After reset, lookup va=0x9FC00010 with k0_uncached=0: next cycle paddr=0x1FC00010, uncache=0, mapped=0, no exc. Repeat with va=0xBFC00010: uncache=1.
- Lookup va=0x00400000 with the TLB empty after reset -> exc_refill=1, paddr=0.
- Write idx 3 with vpn2=0x00200, asid=5, g=0, pfn0=0x12345, c0=3, v0=1, d0=0. Load va=0x00400abc, asid=5 -> paddr=0x12345abc, uncache=0. Same load with asid=6 -> refill. Store with asid=5 -> exc_modified. Odd page va=0x00401000 -> exc_invalid.
- user_mode=1, va=0x80000000 -> exc_addr=1 only.
- tlbp for vpn2=0x00200, asid=5 -> next cycle done=1, hit=1, index=3. Write idx 3 in the same cycle as a lookup -> the lookup returns the old mapping.
- Hold stall=1 for 3 cycles while in_vaddr changes -> outputs frozen. Assert resetn low mid-stall -> outputs 0 immediately, and the entry at idx 3 no longer hits.
